// File: rtl/pipe_ctrl_n.sv
// Pipeline control: per-register stall/bubble vectors, valid tracking, multi-cycle EX FSM, stall counter.
// stall/flush_o are combinational from this cycle's inputs; valid_o, mc_done, perf count are registered; no backpressure.
module pipe_ctrl_n #(
    parameter int STAGES      = 5,
    parameter int REG_ADDR_W  = 5,
    parameter int MC_LAT_W    = 6,
    parameter int FLUSH_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_reg1_read,
    input  logic [REG_ADDR_W-1:0] id_reg1_addr,
    input  logic                  id_reg2_read,
    input  logic [REG_ADDR_W-1:0] id_reg2_addr,
    input  logic                  ex_is_load,
    input  logic                  ex_wreg,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  mc_start,
    input  logic [MC_LAT_W-1:0]   mc_cycles,
    input  logic                  flush,
    input  logic                  perf_clr,
    output logic [STAGES-1:0]     stall,
    output logic [STAGES-1:0]     flush_o,
    output logic [STAGES-1:0]     valid_o,
    output logic                  mc_busy,
    output logic                  mc_done,
    output logic [31:0]           perf_stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

    mc_state_t             state_q, state_d;
    logic [MC_LAT_W-1:0]   cnt_q, cnt_d;
    logic [MC_LAT_W-1:0]   n_eff;
    logic                  done_q, done_d;
    logic                  mc_stall;
    logic                  lu;
    logic [STAGES-1:0]     stall_c, flush_c;
    logic [STAGES-1:0]     valid_q, valid_d;
    logic [31:0]           perf_cnt_q, perf_cnt_d;

    // Register 0 is hardwired and can never be a RAW source.
    always_comb begin
        lu = ex_is_load && ex_wreg && (ex_wd != '0) &&
             ((id_reg1_read && (id_reg1_addr == ex_wd)) ||
              (id_reg2_read && (id_reg2_addr == ex_wd)));
    end

    assign n_eff = (mc_cycles == '0) ? MC_LAT_W'(1) : mc_cycles;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        mc_stall = 1'b0;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mc_start && (n_eff == MC_LAT_W'(2))) begin
                        mc_stall = 1'b1;
                        done_d   = 1'b1;
                    end else if (mc_start && (n_eff > MC_LAT_W'(2))) begin
                        mc_stall = 1'b1;
                        cnt_d    = n_eff - MC_LAT_W'(3);
                        state_d  = BUSY;
                    end
                end
                BUSY: begin
                    mc_stall = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - MC_LAT_W'(1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A register that is itself held keeps its contents, so bubbles only land below the stall boundary.
    always_comb begin
        stall_c = '0;
        flush_c = '0;
        if (rst) begin
            stall_c = '0;
            flush_c = '0;
        end else if (flush) begin
            for (int i = 1; i < STAGES; i++) begin
                if (i <= FLUSH_DEPTH) begin
                    flush_c[i] = 1'b1;
                end
            end
        end else begin
            stall_c[0] = lu | mc_stall;
            stall_c[1] = lu | mc_stall;
            stall_c[2] = mc_stall;
            flush_c[2] = lu & ~mc_stall;
            flush_c[3] = mc_stall;
        end
    end

    always_comb begin
        valid_d    = valid_q;
        valid_d[0] = 1'b1;
        for (int i = 1; i < STAGES; i++) begin
            if (flush_c[i]) begin
                valid_d[i] = 1'b0;
            end else if (stall_c[i]) begin
                valid_d[i] = valid_q[i];
            end else if (stall_c[i-1]) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (perf_clr) begin
            perf_cnt_d = '0;
        end else if (stall_c[0] && (perf_cnt_q != 32'hFFFF_FFFF)) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            valid_q    <= '0;
            perf_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign stall          = stall_c;
    assign flush_o        = flush_c;
    assign valid_o        = valid_q;
    assign mc_busy        = (state_q == BUSY);
    assign mc_done        = done_q;
    assign perf_stall_cnt = perf_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: directed scenarios plus random traffic against a remaining-cycles reference model.
module tb_pipe_ctrl_n;

    localparam int STAGES = 5;
    localparam int RW     = 5;
    localparam int MW     = 6;
    localparam int FD     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_reg1_read, id_reg2_read;
    logic [RW-1:0]     id_reg1_addr, id_reg2_addr;
    logic              ex_is_load, ex_wreg;
    logic [RW-1:0]     ex_wd;
    logic              mc_start;
    logic [MW-1:0]     mc_cycles;
    logic              flush, perf_clr;
    logic [STAGES-1:0] stall, flush_o, valid_o;
    logic              mc_busy, mc_done;
    logic [31:0]       perf_stall_cnt;

    pipe_ctrl_n #(.STAGES(STAGES), .REG_ADDR_W(RW), .MC_LAT_W(MW), .FLUSH_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .id_reg1_read(id_reg1_read), .id_reg1_addr(id_reg1_addr),
        .id_reg2_read(id_reg2_read), .id_reg2_addr(id_reg2_addr),
        .ex_is_load(ex_is_load), .ex_wreg(ex_wreg), .ex_wd(ex_wd),
        .mc_start(mc_start), .mc_cycles(mc_cycles),
        .flush(flush), .perf_clr(perf_clr),
        .stall(stall), .flush_o(flush_o), .valid_o(valid_o),
        .mc_busy(mc_busy), .mc_done(mc_done), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: stall cycles still owed after the start cycle, and a pending done pulse.
    int          m_rem;
    bit          m_done;
    bit [4:0]    m_valid;
    logic [31:0] m_perf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_reg1_read = 1'b0; id_reg1_addr = '0;
        id_reg2_read = 1'b0; id_reg2_addr = '0;
        ex_is_load = 1'b0; ex_wreg = 1'b0; ex_wd = '0;
        mc_start = 1'b0; mc_cycles = '0;
        flush = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic model_reset();
        m_rem = 0; m_done = 1'b0; m_valid = '0; m_perf = '0;
    endtask

    task automatic do_cycle();
        bit       lu, acc, mcs, done_nx;
        int       n;
        bit [4:0] es, ef, nv;
        @(negedge clk);
        n   = (mc_cycles == 0) ? 1 : int'(mc_cycles);
        lu  = ex_is_load && ex_wreg && (ex_wd != 0) &&
              ((id_reg1_read && id_reg1_addr == ex_wd) || (id_reg2_read && id_reg2_addr == ex_wd));
        acc = !flush && mc_start && (m_rem == 0) && (n >= 2);
        mcs = (m_rem > 0) || acc;
        es = '0; ef = '0;
        if (flush) begin
            for (int i = 1; i <= FD; i++) ef[i] = 1'b1;
        end else begin
            if (lu || mcs) es[1:0] = 2'b11;
            if (mcs) begin es[2] = 1'b1; ef[3] = 1'b1; end
            if (lu && !mcs) ef[2] = 1'b1;
        end
        check("stall",   64'(stall),          64'(es));
        check("flush_o", 64'(flush_o),        64'(ef));
        check("valid_o", 64'(valid_o),        64'(m_valid));
        check("mc_busy", 64'(mc_busy),        64'(m_rem > 0));
        check("mc_done", 64'(mc_done),        64'(m_done));
        check("perf",    64'(perf_stall_cnt), 64'(m_perf));
        done_nx = !flush && ((m_rem == 1) || (acc && n == 2));
        if (flush)          m_rem = 0;
        else if (m_rem > 0) m_rem = m_rem - 1;
        else if (acc)       m_rem = n - 2;
        m_done = done_nx;
        nv[0] = 1'b1;
        for (int i = 1; i < STAGES; i++) begin
            if (ef[i])        nv[i] = 1'b0;
            else if (es[i])   nv[i] = m_valid[i];
            else if (es[i-1]) nv[i] = 1'b0;
            else              nv[i] = m_valid[i-1];
        end
        m_valid = nv;
        if (perf_clr)                                m_perf = '0;
        else if (es[0] && m_perf != 32'hFFFF_FFFF)   m_perf = m_perf + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [RW-1:0] wd, input logic [RW-1:0] rt);
        ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = wd;
        id_reg2_read = 1'b1; id_reg2_addr = rt;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #2;
        check("rst_stall",   64'(stall),          64'(0));
        check("rst_flush",   64'(flush_o),        64'(0));
        check("rst_valid",   64'(valid_o),        64'(0));
        check("rst_busy",    64'(mc_busy),        64'(0));
        check("rst_done",    64'(mc_done),        64'(0));
        check("rst_perf",    64'(perf_stall_cnt), 64'(0));
        // Hazard and flush inputs during reset must not leak to combinational outputs.
        set_load_use(5'd7, 5'd7);
        flush = 1'b1;
        #1;
        check("rst_lu_stall", 64'(stall),   64'(0));
        check("rst_lu_flush", 64'(flush_o), 64'(0));
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            do_cycle();
            check("fill", 64'(valid_o), 64'((1 << (k + 1)) - 1));
        end

        set_load_use(5'd5, 5'd5);
        do_cycle();
        clear_inputs();
        check("lu_bubble_v2", 64'(valid_o[2]), 64'(0));
        do_cycle();
        set_load_use(5'd0, 5'd0);
        do_cycle();
        clear_inputs();
        do_cycle();

        perf_clr = 1'b1;
        do_cycle();
        perf_clr = 1'b0;
        mc_start = 1'b1; mc_cycles = 6'd4;
        do_cycle();
        clear_inputs();
        for (int k = 0; k < 4; k++) do_cycle();
        check("mc4_perf", 64'(perf_stall_cnt), 64'(3));

        for (int c = 2; c >= 0; c--) begin
            mc_start = 1'b1; mc_cycles = 6'(c);
            do_cycle();
            clear_inputs();
            for (int k = 0; k < 3; k++) do_cycle();
        end

        mc_start = 1'b1; mc_cycles = 6'd10;
        do_cycle();
        clear_inputs();
        do_cycle();
        do_cycle();
        flush = 1'b1;
        do_cycle();
        flush = 1'b0;
        check("flush_busy_drop", 64'(mc_busy), 64'(0));
        for (int k = 0; k < 12; k++) do_cycle();

        mc_start = 1'b1; mc_cycles = 6'd5;
        flush = 1'b1;
        do_cycle();
        clear_inputs();
        for (int k = 0; k < 5; k++) do_cycle();

        force dut.perf_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.perf_cnt_q;
        m_perf = 32'hFFFF_FFFE;
        set_load_use(5'd9, 5'd9);
        for (int k = 0; k < 3; k++) do_cycle();
        clear_inputs();
        check("perf_sat", 64'(perf_stall_cnt), 64'(32'hFFFF_FFFF));
        set_load_use(5'd9, 5'd9);
        perf_clr = 1'b1;
        do_cycle();
        clear_inputs();
        check("perf_clr", 64'(perf_stall_cnt), 64'(0));

        mc_start = 1'b1; mc_cycles = 6'd10;
        do_cycle();
        clear_inputs();
        do_cycle();
        do_cycle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",  64'(mc_busy),        64'(0));
        check("arst_valid", 64'(valid_o),        64'(0));
        check("arst_stall", 64'(stall),          64'(0));
        check("arst_flush", 64'(flush_o),        64'(0));
        check("arst_perf",  64'(perf_stall_cnt), 64'(0));
        check("arst_done",  64'(mc_done),        64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) do_cycle();

        for (int k = 0; k < 1500; k++) begin
            id_reg1_read = 1'($urandom_range(0, 1));
            id_reg2_read = 1'($urandom_range(0, 1));
            id_reg1_addr = RW'($urandom_range(0, 3));
            id_reg2_addr = RW'($urandom_range(0, 3));
            ex_is_load   = 1'($urandom_range(0, 3) == 0);
            ex_wreg      = 1'($urandom_range(0, 3) != 0);
            ex_wd        = RW'($urandom_range(0, 3));
            mc_start     = 1'($urandom_range(0, 7) == 0);
            mc_cycles    = ($urandom_range(0, 15) == 0) ? 6'd63 : MW'($urandom_range(0, 12));
            flush        = 1'($urandom_range(0, 29) == 0);
            perf_clr     = 1'($urandom_range(0, 49) == 0);
            do_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
